// File: rtl/dec_7s_scan_controller_if.sv
// Load handshake, display control and multiplexed display pins of the 7-segment scanner.
interface dec_7s_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] LOAD_DATA;
  logic                    LOAD_VALID;
  logic                    LOAD_READY;
  logic                    LZ_BLANK;
  logic [6:0]              SEG;
  logic [NUM_DIGITS-1:0]   DIG;
  logic                    FRAME;

  modport master (
    output LOAD_DATA, LOAD_VALID, LZ_BLANK,
    input  LOAD_READY, SEG, DIG, FRAME
  );

  modport slave (
    input  LOAD_DATA, LOAD_VALID, LZ_BLANK,
    output LOAD_READY, SEG, DIG, FRAME
  );
endinterface

// File: rtl/dec_7s_scan_controller.sv
// Multiplexed 7-segment scanner: shared decoder, BLANK gap before every digit, registered pins.
// Loads land in a shadow word (READY=0 while pending) and commit to the display only at FRAME.
module dec_7s_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 50000,
  parameter int DWELL_TICKS = 4,
  parameter int DEAD_TICKS  = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  dec_7s_scan_controller_if.slave bus
);
  localparam int DW     = 4 * NUM_DIGITS;
  localparam int PW     = $clog2(TICK_DIV);
  localparam int IW     = $clog2(NUM_DIGITS);
  localparam int PH_MAX = (DWELL_TICKS > DEAD_TICKS) ? DWELL_TICKS : DEAD_TICKS;
  localparam int CW     = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_TICKS - 1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_phase;
  logic [IW-1:0]   r_idx;
  logic [PW-1:0]   r_presc;
  logic [DW-1:0]   r_active;
  logic [DW-1:0]   r_shadow;
  logic            r_pending;
  logic            r_ready;
  logic [6:0]      r_seg;
  logic [NUM_DIGITS-1:0] r_dig;
  logic            r_frame;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_phase_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic [PW-1:0]   w_presc_nxt;
  logic [DW-1:0]   w_active_nxt;
  logic [DW-1:0]   w_shadow_nxt;
  logic            w_pending_nxt;
  logic            w_ready_nxt;
  logic [6:0]      w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_dig_nxt;
  logic            w_frame_nxt;
  logic            w_tick;
  logic            w_capture;
  logic            w_commit;
  logic            w_lead_zero;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_capture = bus.LOAD_VALID & r_ready;
  // FRAME is high in the first BLANK cycle of a frame, so a commit here never tears a digit.
  assign w_commit  = r_frame & r_pending;

  always_comb begin
    w_presc_nxt   = w_tick ? '0 : r_presc + 1'b1;
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_idx_nxt     = r_idx;
    w_frame_nxt   = 1'b0;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    w_active_nxt  = r_active;
    w_ready_nxt   = r_ready;
    w_seg_nxt     = SEG_OFF;
    w_dig_nxt     = '1;
    w_lead_zero   = 1'b1;

    if (w_tick) begin
      case (r_state)
        ST_BLANK: begin
          if (r_phase == DEAD_LAST) begin
            w_state_nxt = ST_SHOW;
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase + 1'b1;
          end
        end
        ST_SHOW: begin
          if (r_phase == DWELL_LAST) begin
            w_state_nxt = ST_BLANK;
            w_phase_nxt = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt   = '0;
              w_frame_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_phase_nxt = r_phase + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_BLANK;
          w_phase_nxt = '0;
        end
      endcase
    end

    // Capture and commit are exclusive: capture needs pending=0, commit needs pending=1.
    if (w_capture) begin
      w_shadow_nxt  = bus.LOAD_DATA;
      w_pending_nxt = 1'b1;
    end
    if (w_commit) begin
      w_active_nxt  = r_shadow;
      w_pending_nxt = 1'b0;
    end
    w_ready_nxt = ~w_pending_nxt;

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(w_idx_nxt)) && (w_active_nxt[4*k +: 4] != 4'd0)) begin
        w_lead_zero = 1'b0;
      end
    end

    // Pins are computed from next-cycle state so they line up exactly with the FSM state.
    if (w_state_nxt == ST_SHOW) begin
      w_dig_nxt[w_idx_nxt] = 1'b0;
      if (bus.LZ_BLANK && w_lead_zero && (w_idx_nxt != '0)) begin
        w_seg_nxt = SEG_OFF;
      end else begin
        w_seg_nxt = seg_decode(w_active_nxt[{w_idx_nxt, 2'b00} +: 4]);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_BLANK;
      r_phase   <= '0;
      r_idx     <= '0;
      r_presc   <= '0;
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
      r_seg     <= SEG_OFF;
      r_dig     <= '1;
      r_frame   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_idx     <= w_idx_nxt;
      r_presc   <= w_presc_nxt;
      r_active  <= w_active_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_ready   <= w_ready_nxt;
      r_seg     <= w_seg_nxt;
      r_dig     <= w_dig_nxt;
      r_frame   <= w_frame_nxt;
    end
  end

  assign bus.SEG        = r_seg;
  assign bus.DIG        = r_dig;
  assign bus.FRAME      = r_frame;
  assign bus.LOAD_READY = r_ready;
endmodule

// File: tb/tb_dec_7s_scan_controller.sv
// Directed bench for dec_7s_scan_controller: 2 digits, 8-clock digit slot, 16-clock frame.
module tb_dec_7s_scan_controller;
  localparam int ND = 2;
  localparam int TD = 2;
  localparam int DW = 3;
  localparam int DT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic [ND-1:0] prev_dig = '1;

  always #5 clk = ~clk;

  dec_7s_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

  dec_7s_scan_controller #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .DWELL_TICKS(DW), .DEAD_TICKS(DT)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .bus     (bus)
  );

  // Continuous digit-enable safety: at most one digit low, and no digit-to-digit handover without a gap.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      n_vec++;
      if ($countones(~bus.DIG) > 1) begin
        n_err++;
        $display("FAIL dig_onehot t=%0t: DIG=%b, required at most one 0", $time, bus.DIG);
      end
      n_vec++;
      if ((prev_dig != '1) && (bus.DIG != '1) && (prev_dig != bus.DIG)) begin
        n_err++;
        $display("FAIL dig_gap t=%0t: DIG %b -> %b, required an all-off gap", $time, prev_dig, bus.DIG);
      end
    end
    prev_dig = bus.DIG;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_to(input int c);
    step(c - cyc);
  endtask

  // Releases reset just after a rising edge; the current sample point is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    bus.LOAD_VALID = 1'b0;
    bus.LOAD_DATA  = '0;
    bus.LZ_BLANK   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic load_word(input logic [4*ND-1:0] d);
    bus.LOAD_DATA  = d;
    bus.LOAD_VALID = 1'b1;
    step(1);
    bus.LOAD_VALID = 1'b0;
  endtask

  task automatic test_reset();
    bus.LOAD_VALID = 1'b0;
    bus.LOAD_DATA  = '0;
    bus.LZ_BLANK   = 1'b0;
    #12;
    n_vec++;
    if (bus.SEG !== 7'h7F) begin n_err++; $display("FAIL rst_seg: got %h, required 7f", bus.SEG); end
    n_vec++;
    if (bus.DIG !== 2'b11) begin n_err++; $display("FAIL rst_dig: got %b, required 11", bus.DIG); end
    n_vec++;
    if (bus.FRAME !== 1'b0) begin n_err++; $display("FAIL rst_frame: got %b, required 0", bus.FRAME); end
    n_vec++;
    if (bus.LOAD_READY !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b, required 1", bus.LOAD_READY); end
  endtask

  task automatic test_scan();
    logic [ND-1:0] e_dig;
    logic [6:0]    e_seg;
    logic          e_frame;
    int            p;
    do_reset();
    mon_en = 1'b1;
    for (int c = 0; c < 34; c++) begin
      p       = c % 16;
      e_dig   = (p >= 2 && p <= 7) ? 2'b10 : (p >= 10) ? 2'b01 : 2'b11;
      e_seg   = (e_dig == 2'b11) ? 7'h7F : 7'h40;
      e_frame = (c == 16) || (c == 32);
      n_vec++;
      if (bus.DIG !== e_dig) begin n_err++; $display("FAIL scan_dig c%0d: got %b, required %b", c, bus.DIG, e_dig); end
      n_vec++;
      if (bus.SEG !== e_seg) begin n_err++; $display("FAIL scan_seg c%0d: got %h, required %h", c, bus.SEG, e_seg); end
      n_vec++;
      if (bus.FRAME !== e_frame) begin n_err++; $display("FAIL scan_frame c%0d: got %b, required %b", c, bus.FRAME, e_frame); end
      step(1);
    end
  endtask

  task automatic test_load();
    do_reset();
    run_to(4);
    load_word(8'h93);
    n_vec++;
    if (bus.LOAD_READY !== 1'b0) begin n_err++; $display("FAIL load_rdy_drop: got %b, required 0", bus.LOAD_READY); end
    n_vec++;
    if (bus.SEG !== 7'h40) begin n_err++; $display("FAIL load_old_d0: got %h, required 40", bus.SEG); end
    run_to(12);
    n_vec++;
    if (bus.SEG !== 7'h40) begin n_err++; $display("FAIL load_old_d1: got %h, required 40", bus.SEG); end
    run_to(16);
    n_vec++;
    if ({bus.FRAME, bus.LOAD_READY} !== 2'b10) begin n_err++; $display("FAIL load_frame: got %b, required 10", {bus.FRAME, bus.LOAD_READY}); end
    step(1);
    n_vec++;
    if (bus.LOAD_READY !== 1'b1) begin n_err++; $display("FAIL load_rdy_back: got %b, required 1", bus.LOAD_READY); end
    run_to(18);
    n_vec++;
    if ({bus.DIG, bus.SEG} !== {2'b10, 7'h30}) begin n_err++; $display("FAIL load_new_d0: got %b/%h, required 10/30", bus.DIG, bus.SEG); end
    run_to(26);
    n_vec++;
    if ({bus.DIG, bus.SEG} !== {2'b01, 7'h10}) begin n_err++; $display("FAIL load_new_d1: got %b/%h, required 01/10", bus.DIG, bus.SEG); end
  endtask

  task automatic test_hold();
    do_reset();
    bus.LOAD_DATA  = 8'h93;
    bus.LOAD_VALID = 1'b1;
    step(1);
    bus.LOAD_DATA  = 8'h55;
    n_vec++;
    if (bus.LOAD_READY !== 1'b0) begin n_err++; $display("FAIL hold_rdy_low: got %b, required 0", bus.LOAD_READY); end
    run_to(17);
    n_vec++;
    if (bus.LOAD_READY !== 1'b1) begin n_err++; $display("FAIL hold_rdy_back: got %b, required 1", bus.LOAD_READY); end
    step(1);
    bus.LOAD_VALID = 1'b0;
    n_vec++;
    if (bus.LOAD_READY !== 1'b0) begin n_err++; $display("FAIL hold_recapture: got %b, required 0", bus.LOAD_READY); end
    n_vec++;
    if (bus.SEG !== 7'h30) begin n_err++; $display("FAIL hold_first_word: got %h, required 30", bus.SEG); end
    run_to(34);
    n_vec++;
    if (bus.SEG !== 7'h12) begin n_err++; $display("FAIL hold_new_d0: got %h, required 12", bus.SEG); end
    run_to(42);
    n_vec++;
    if ({bus.DIG, bus.SEG} !== {2'b01, 7'h12}) begin n_err++; $display("FAIL hold_new_d1: got %b/%h, required 01/12", bus.DIG, bus.SEG); end
  endtask

  task automatic test_lz();
    do_reset();
    bus.LZ_BLANK = 1'b1;
    load_word(8'h07);
    run_to(2);
    n_vec++;
    if (bus.SEG !== 7'h40) begin n_err++; $display("FAIL lz_d0_never: got %h, required 40", bus.SEG); end
    run_to(10);
    n_vec++;
    if ({bus.DIG, bus.SEG} !== {2'b01, 7'h7F}) begin n_err++; $display("FAIL lz_zero_d1: got %b/%h, required 01/7f", bus.DIG, bus.SEG); end
    run_to(18);
    n_vec++;
    if ({bus.DIG, bus.SEG} !== {2'b10, 7'h78}) begin n_err++; $display("FAIL lz07_d0: got %b/%h, required 10/78", bus.DIG, bus.SEG); end
    run_to(26);
    n_vec++;
    if ({bus.DIG, bus.SEG} !== {2'b01, 7'h7F}) begin n_err++; $display("FAIL lz07_d1: got %b/%h, required 01/7f", bus.DIG, bus.SEG); end
    load_word(8'h00);
    run_to(34);
    n_vec++;
    if (bus.SEG !== 7'h40) begin n_err++; $display("FAIL lz00_d0: got %h, required 40", bus.SEG); end
    run_to(42);
    n_vec++;
    if ({bus.DIG, bus.SEG} !== {2'b01, 7'h7F}) begin n_err++; $display("FAIL lz00_d1: got %b/%h, required 01/7f", bus.DIG, bus.SEG); end
    run_to(43);
    bus.LZ_BLANK = 1'b0;
    step(1);
    n_vec++;
    if ({bus.DIG, bus.SEG} !== {2'b01, 7'h40}) begin n_err++; $display("FAIL lz_off_live: got %b/%h, required 01/40", bus.DIG, bus.SEG); end
  endtask

  task automatic test_dash();
    do_reset();
    load_word(8'hA5);
    run_to(18);
    n_vec++;
    if (bus.SEG !== 7'h12) begin n_err++; $display("FAIL dash_d0: got %h, required 12", bus.SEG); end
    run_to(26);
    n_vec++;
    if ({bus.DIG, bus.SEG} !== {2'b01, 7'h3F}) begin n_err++; $display("FAIL dash_d1: got %b/%h, required 01/3f", bus.DIG, bus.SEG); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_word(8'h93);
    run_to(20);
    load_word(8'h55);
    n_vec++;
    if (bus.LOAD_READY !== 1'b0) begin n_err++; $display("FAIL rmid_pending: got %b, required 0", bus.LOAD_READY); end
    run_to(22);
    n_vec++;
    if ({bus.DIG, bus.SEG} !== {2'b10, 7'h30}) begin n_err++; $display("FAIL rmid_show: got %b/%h, required 10/30", bus.DIG, bus.SEG); end
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.DIG, bus.SEG, bus.FRAME, bus.LOAD_READY} !== {2'b11, 7'h7F, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rmid_async: got dig=%b seg=%h frame=%b rdy=%b, required 11/7f/0/1", bus.DIG, bus.SEG, bus.FRAME, bus.LOAD_READY);
    end
    do_reset();
    run_to(2);
    n_vec++;
    if (bus.SEG !== 7'h40) begin n_err++; $display("FAIL rmid_clr_d0: got %h, required 40", bus.SEG); end
    run_to(10);
    n_vec++;
    if (bus.SEG !== 7'h40) begin n_err++; $display("FAIL rmid_clr_d1: got %h, required 40", bus.SEG); end
    run_to(26);
    n_vec++;
    if (bus.SEG !== 7'h40) begin n_err++; $display("FAIL rmid_no_commit: got %h, required 40", bus.SEG); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_hold();
    test_lz();
    test_dash();
    test_reset_mid();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
